fir_filter_pipe: RTL and testbench

- Parametrised, pipelined direct-form FIR with an internal delay line and a streaming valid strobe.
- Coefficients are runtime-loadable through a double-buffered bank (shadow and active) with an atomic commit.
- Output is rounded and saturated to a configurable signed fixed-point format, with a saturation flag.
- Successor to the fixed 8-tap combinational filter; sits between the sample source and the downstream decimator/DAC path.

---
 rtl/fir_pkg.sv | 70 +++++++
 rtl/fir_round_sat.sv | 41 ++++
 rtl/fir_filter_pipe.sv | 155 +++++++++++++++
 tb/tb_fir_filter_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared helpers for the FIR filter and the downstream decimator.
// Holds width arithmetic (clog2, product/full/fraction widths, tree level
// sizes) and the round-half-up + saturate function used by the output stage.
package fir_pkg;

  // Width of the scratch arithmetic used by round_sat; wide enough for any
  // accumulator this family of filters produces.
  localparam int RS_W = 64;

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   sat;
  } round_sat_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r++;
    end
    return r;
  endfunction

  // Full-precision product width of a data sample times a coefficient.
  function automatic int nb_prod(input int nb_data, input int nb_coeff);
    return nb_data + nb_coeff;
  endfunction

  // Accumulator width that cannot overflow when summing n_coeffs products.
  function automatic int nb_full(input int nb_data, input int nb_coeff, input int n_coeffs);
    return nb_data + nb_coeff + clog2(n_coeffs);
  endfunction

  // Fractional bits of the full-precision accumulator.
  function automatic int frac_full(input int nb_frac_data, input int nb_frac_coeff);
    return nb_frac_data + nb_frac_coeff;
  endfunction

  // Number of live operands at adder-tree level lvl (level 0 = products).
  function automatic int level_count(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  // Round half-up by d fractional bits, then clip to a signed nb_out range.
  // sat reports whether clipping happened.
  function automatic round_sat_t round_sat(input logic signed [RS_W-1:0] x,
                                           input int d, input int nb_out);
    round_sat_t             res;
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] rnd;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    one = 1;
    rnd = (x + (one <<< (d - 1))) >>> d;
    hi  = (one <<< (nb_out - 1)) - one;
    lo  = -hi - one;
    res.sat = 1'b0;
    res.val = rnd;
    if (rnd > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (rnd < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: registered round-half-up by D bits and saturation to NB_OUT.
// Ports: clk/rst; sum_valid + sum (NB_IN signed) in; res_valid, res_data
// (NB_OUT signed) and res_sat out. One cycle latency; outputs hold when idle.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int NB_IN  = 19,
  parameter int D      = 4,
  parameter int NB_OUT = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sum_valid,
  input  logic signed [NB_IN-1:0]  sum,
  output logic                     res_valid,
  output logic signed [NB_OUT-1:0] res_data,
  output logic                     res_sat
);

  round_sat_t rs;

  always_comb begin
    rs = round_sat(RS_W'(sum), D, NB_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_sat   <= 1'b0;
    end else begin
      res_valid <= sum_valid;
      // Data and flag only move with a valid result so they hold otherwise.
      if (sum_valid) begin
        res_data <= NB_OUT'(rs.val);
        res_sat  <= rs.sat;
      end
    end
  end

endmodule

// File: rtl/fir_filter_pipe.sv
// fir_filter_pipe: pipelined direct-form FIR with double-buffered coefficients.
// Ports: clk, i_rst; i_valid/i_data sample stream; i_coeff_we/addr/data shadow
// writes and i_coeff_commit; o_valid/o_data/o_sat result stream.
// Latency clog2(N_COEFFS)+3 cycles, no backpressure, any i_valid pattern.
module fir_filter_pipe
  import fir_pkg::*;
#(
  parameter int NB_DATA_IN    = 8,
  parameter int NB_FRAC_IN    = 7,
  parameter int NB_COEFF      = 8,
  parameter int NB_FRAC_COEFF = 7,
  parameter int N_COEFFS      = 8,
  parameter int NB_DATA_OUT   = 12,
  parameter int NB_FRAC_OUT   = 10
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic signed [NB_DATA_IN-1:0]  i_data,
  input  logic                          i_coeff_we,
  input  logic [clog2(N_COEFFS)-1:0]    i_coeff_addr,
  input  logic signed [NB_COEFF-1:0]    i_coeff_data,
  input  logic                          i_coeff_commit,
  output logic                          o_valid,
  output logic signed [NB_DATA_OUT-1:0] o_data,
  output logic                          o_sat
);

  localparam int LOG_N = clog2(N_COEFFS);
  localparam int AW    = LOG_N;
  localparam int NB_P  = nb_prod(NB_DATA_IN, NB_COEFF);
  localparam int NB_F  = nb_full(NB_DATA_IN, NB_COEFF, N_COEFFS);
  localparam int D     = frac_full(NB_FRAC_IN, NB_FRAC_COEFF) - NB_FRAC_OUT;

  logic signed [NB_DATA_IN-1:0] taps   [N_COEFFS];
  logic signed [NB_COEFF-1:0]   shadow [N_COEFFS];
  logic signed [NB_COEFF-1:0]   active [N_COEFFS];
  logic signed [NB_P-1:0]       prod   [N_COEFFS];
  logic                         vld_s0;
  logic                         vld_s1;
  logic                         addr_ok;

  // Only a non-power-of-two tap count leaves unused addresses to reject.
  if ((1 << AW) == N_COEFFS) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = ({1'b0, i_coeff_addr} < (AW + 1)'(N_COEFFS));
  end

  // S0: delay line, tap 0 is the newest sample.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      vld_s0 <= 1'b0;
      for (int k = 0; k < N_COEFFS; k++) begin
        taps[k] <= '0;
      end
    end else begin
      vld_s0 <= i_valid;
      if (i_valid) begin
        taps[0] <= i_data;
        for (int k = 1; k < N_COEFFS; k++) begin
          taps[k] <= taps[k-1];
        end
      end
    end
  end

  // Coefficient banks. Non-blocking copy means a commit in the same cycle as
  // a write takes the shadow contents from before that write.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_COEFFS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (i_coeff_commit) begin
        active <= shadow;
      end
      if (i_coeff_we && addr_ok) begin
        shadow[i_coeff_addr] <= i_coeff_data;
      end
    end
  end

  // S1: all products of one sample are formed in the same cycle, so a result
  // can never combine coefficients from two different commits.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      vld_s1 <= 1'b0;
      for (int k = 0; k < N_COEFFS; k++) begin
        prod[k] <= '0;
      end
    end else begin
      vld_s1 <= vld_s0;
      for (int k = 0; k < N_COEFFS; k++) begin
        prod[k] <= NB_P'(taps[k]) * NB_P'(active[k]);
      end
    end
  end

  // Adder tree. Every level except the root is stored with an even number of
  // entries; the padding entries are zero so the next level always sums pairs.
  for (genvar l = 0; l <= LOG_N; l++) begin : g_lvl
    localparam int CNT  = level_count(N_COEFFS, l);
    localparam int SIZE = (l == LOG_N) ? 1 : 2 * level_count(N_COEFFS, l + 1);

    logic signed [NB_F-1:0] node [SIZE];
    logic                   vld;

    if (l == 0) begin : g_leaf
      assign vld = vld_s1;
      always_comb begin
        for (int k = 0; k < N_COEFFS; k++) begin
          node[k] = NB_F'(prod[k]);
        end
        for (int k = N_COEFFS; k < SIZE; k++) begin
          node[k] = '0;
        end
      end
    end else begin : g_add
      always_ff @(posedge clk) begin
        if (i_rst) begin
          vld <= 1'b0;
          for (int k = 0; k < SIZE; k++) begin
            node[k] <= '0;
          end
        end else begin
          vld <= g_lvl[l-1].vld;
          for (int k = 0; k < CNT; k++) begin
            node[k] <= g_lvl[l-1].node[2*k] + g_lvl[l-1].node[2*k+1];
          end
          for (int k = CNT; k < SIZE; k++) begin
            node[k] <= '0;
          end
        end
      end
    end
  end

  fir_round_sat #(
    .NB_IN  (NB_F),
    .D      (D),
    .NB_OUT (NB_DATA_OUT)
  ) u_round_sat (
    .clk       (clk),
    .rst       (i_rst),
    .sum_valid (g_lvl[LOG_N].vld),
    .sum       (g_lvl[LOG_N].node[0]),
    .res_valid (o_valid),
    .res_data  (o_data),
    .res_sat   (o_sat)
  );

endmodule

// File: tb/tb_fir_filter_pipe.sv
// Bench for fir_filter_pipe with default parameters (8 taps, D=4, 12-bit out).
// A reference model holds sample history and coefficient banks as integers,
// computes each result with plain arithmetic, and schedules it 6 cycles out.
module tb_fir_filter_pipe;

  localparam int N     = 8;
  localparam int D     = 7 + 7 - 10;
  localparam int LAT   = 3 + 3;
  localparam int OUT_HI = 2047;
  localparam int OUT_LO = -2048;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid;
  logic signed [7:0] data;
  logic              we;
  logic [2:0]        caddr;
  logic signed [7:0] cdata;
  logic              commit;
  logic              o_valid;
  logic signed [11:0] o_data;
  logic              o_sat;

  always #5 clk = ~clk;

  fir_filter_pipe dut (
    .clk            (clk),
    .i_rst          (rst),
    .i_valid        (valid),
    .i_data         (data),
    .i_coeff_we     (we),
    .i_coeff_addr   (caddr),
    .i_coeff_data   (cdata),
    .i_coeff_commit (commit),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_sat          (o_sat)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int  hist   [N];
  int  shadow [N];
  int  active [N];
  bit  pv     [16];
  int  pd     [16];
  bit  ps     [16];
  int  ecnt   = 0;
  bit  exp_v  = 1'b0;
  int  exp_d  = 0;
  bit  exp_s  = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Applies the rules of one rising edge to the model, reading the inputs.
  task automatic model_edge();
    int     slot;
    longint acc;
    longint r;
    bit     s;
    slot = ecnt % 16;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        hist[k] = 0; shadow[k] = 0; active[k] = 0;
      end
      for (int i = 0; i < 16; i++) pv[i] = 1'b0;
      exp_v = 1'b0; exp_d = 0; exp_s = 1'b0;
    end else begin
      exp_v = pv[slot];
      if (pv[slot]) begin
        exp_d = pd[slot];
        exp_s = ps[slot];
        pv[slot] = 1'b0;
      end
      if (commit) active = shadow;
      if (we && int'(caddr) < N) shadow[caddr] = int'(cdata);
      if (valid) begin
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(data);
        acc = 0;
        for (int k = 0; k < N; k++) acc += longint'(hist[k]) * longint'(active[k]);
        r = (acc + (longint'(1) << (D - 1))) >>> D;
        s = 1'b0;
        if (r > OUT_HI) begin r = OUT_HI; s = 1'b1; end
        if (r < OUT_LO) begin r = OUT_LO; s = 1'b1; end
        pv[(ecnt + LAT - 1) % 16] = 1'b1;
        pd[(ecnt + LAT - 1) % 16] = int'(r);
        ps[(ecnt + LAT - 1) % 16] = s;
      end
    end
    ecnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("o_valid", o_valid, exp_v);
    check("o_data", o_data, exp_d);
    check("o_sat", o_sat, exp_s);
  endtask

  task automatic load_all(input int v);
    for (int k = 0; k < N; k++) begin
      we = 1'b1; caddr = 3'(k); cdata = 8'(v);
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    int rnd_in  [4];
    int rnd_exp [4];
    int pulses;
    rnd_in  = '{8, 7, -8, -9};
    rnd_exp = '{1, 0, 0, -1};

    rst = 1'b1; valid = 1'b0; data = '0; we = 1'b0; caddr = '0; cdata = '0; commit = 1'b0;
    @(negedge clk);
    tick(); tick();
    check("reset_o_valid", o_valid, 0);
    check("reset_o_data", o_data, 0);
    check("reset_o_sat", o_sat, 0);
    rst = 1'b0;

    // Impulse through coefficients 1..8.
    for (int k = 0; k < N; k++) begin
      we = 1'b1; caddr = 3'(k); cdata = 8'(k + 1);
      tick();
    end
    we = 1'b0; commit = 1'b1; tick(); commit = 1'b0;
    valid = 1'b1; data = 8'h40; tick(); data = 8'h00;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == LAT - 2) check("impulse_early", o_valid, 0);
      if (c == LAT - 1) begin
        check("impulse_first_valid", o_valid, 1);
        check("impulse_first_data", o_data, 4);
      end
      if (c == LAT + 6) check("impulse_last_data", o_data, 32);
      if (c == LAT + 7) check("impulse_tail_zero", o_data, 0);
    end

    // Positive and negative saturation.
    load_all(8'h7F);
    commit = 1'b1; tick(); commit = 1'b0;
    data = 8'h7F;
    repeat (14) tick();
    check("pos_sat_data", o_data, 2047);
    check("pos_sat_flag", o_sat, 1);
    data = 8'h80;
    repeat (14) tick();
    check("neg_sat_data", o_data, -2048);
    check("neg_sat_flag", o_sat, 1);

    // Rounding with a single unit coefficient.
    valid = 1'b0;
    load_all(0);
    we = 1'b1; caddr = 3'd0; cdata = 8'sd1; tick(); we = 1'b0;
    commit = 1'b1; tick(); commit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; data = 8'(rnd_in[i]); tick(); valid = 1'b0;
      repeat (LAT - 1) tick();
      check("round_valid", o_valid, 1);
      check("round_data", o_data, rnd_exp[i]);
    end

    // Random stream with gaps: set A live, B loaded mid-stream, commits.
    for (int k = 0; k < N; k++) begin
      we = 1'b1; caddr = 3'(k); cdata = 8'($urandom);
      tick();
    end
    we = 1'b0; commit = 1'b1; tick(); commit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      valid = ($urandom_range(0, 3) != 0);
      data = 8'($urandom);
      we = 1'b0; commit = 1'b0;
      if (c >= 10 && c < 18) begin
        we = 1'b1; caddr = 3'(c - 10); cdata = 8'($urandom);
      end
      if (c == 25) begin valid = 1'b1; commit = 1'b1; end
      if (c == 35) begin
        valid = 1'b1; commit = 1'b1; we = 1'b1; caddr = 3'd3; cdata = 8'($urandom);
      end
      if (c == 45) begin valid = 1'b1; commit = 1'b1; end
      if (c == 50) commit = 1'b1;
      tick();
    end
    we = 1'b0; commit = 1'b0; valid = 1'b0;
    repeat (LAT + 2) tick();

    // Reset with five samples in flight.
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = 8'($urandom);
      tick();
    end
    valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check("midreset_o_valid", o_valid, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_valid) pulses++;
    end
    check("midreset_late_pulses", pulses, 0);
    valid = 1'b1; data = 8'h40; tick(); valid = 1'b0;
    repeat (LAT - 1) tick();
    check("postreset_valid", o_valid, 1);
    check("postreset_data", o_data, 0);
    check("postreset_sat", o_sat, 0);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
